// File: rtl/gs_rom_loadable.sv
// Loader-writable ROM/RAM: packs loader bytes into DATA_W words, request/valid read port.
// Define GS_ROM_LOADABLE_CSUM_EN to add the 16-bit byte checksum port csum.
module gs_rom_loadable #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 15,
    parameter int SEL_BIT = 31,
    parameter int RD_LAT  = 1
) (
    input  logic              clk_bus,
    input  logic              reset_n,
    input  logic              loader_act,
    input  logic [31:0]       loader_a,
    input  logic [7:0]        loader_d,
    input  logic              loader_wr,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              ready,
    output logic [23:0]       load_count
`ifdef GS_ROM_LOADABLE_CSUM_EN
    ,
    output logic [15:0]       csum
`endif
);
    localparam int LANES = DATA_W / 8;
    localparam int LW    = $clog2(LANES);
    localparam int LWX   = (LW == 0) ? 1 : LW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_RDY
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] pend_word_q, pend_word_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [LANES-1:0]  pend_mask_q, pend_mask_d;
    logic [23:0]       cnt_q, cnt_d;

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic              hit;
    logic [ADDR_W-1:0] hit_word;
    logic [LWX-1:0]    hit_lane;
    logic              same;
    logic              entry;
    logic [DATA_W-1:0] merge_word;
    logic [LANES-1:0]  merge_mask;

    logic              unused_ok;

    assign unused_ok = ^loader_a;
    assign hit       = loader_act & loader_wr & loader_a[SEL_BIT];
    assign hit_word  = ADDR_W'(loader_a >> LW);
    assign hit_lane  = (LANES == 1) ? '0 : loader_a[LWX-1:0];
    assign ready     = (state_q == S_RDY);
    assign load_count = cnt_q;

    // Lanes never written in this word read back as erased flash.
    function automatic logic [DATA_W-1:0] ff_fill(
        input logic [DATA_W-1:0] w,
        input logic [LANES-1:0]  m
    );
        logic [DATA_W-1:0] r;
        r = '1;
        for (int l = 0; l < LANES; l++) begin
            if (m[l]) r[l*8 +: 8] = w[l*8 +: 8];
        end
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (loader_act) state_d = S_LOAD;
            S_RDY:   if (loader_act) state_d = S_LOAD;
            S_LOAD:  if (!loader_act) state_d = S_FLUSH;
            S_FLUSH: state_d = S_RDY;
            default: state_d = S_IDLE;
        endcase
        entry = loader_act && (state_q == S_IDLE || state_q == S_RDY);
        cnt_d = entry ? 24'd0 : cnt_q;
        if (hit && cnt_d != 24'hFFFFFF) cnt_d = cnt_d + 24'd1;
    end

    always_comb begin
        pend_word_d = pend_word_q;
        pend_addr_d = pend_addr_q;
        pend_mask_d = pend_mask_q;
        mem_we      = 1'b0;
        mem_waddr   = pend_addr_q;
        mem_wdata   = ff_fill(pend_word_q, pend_mask_q);
        same        = (pend_mask_q == '0) || (hit_word == pend_addr_q);
        merge_word  = pend_word_q;
        merge_mask  = same ? pend_mask_q : '0;
        for (int l = 0; l < LANES; l++) begin
            if (LWX'(l) == hit_lane) begin
                merge_word[l*8 +: 8] = loader_d;
                merge_mask[l]        = 1'b1;
            end
        end
        if (hit) begin
            if (!same) begin
                mem_we      = 1'b1;
                pend_word_d = merge_word;
                pend_mask_d = merge_mask;
                pend_addr_d = hit_word;
            end else if (hit_lane == LWX'(LANES - 1)) begin
                mem_we      = 1'b1;
                mem_waddr   = hit_word;
                mem_wdata   = ff_fill(merge_word, merge_mask);
                pend_mask_d = '0;
            end else begin
                pend_word_d = merge_word;
                pend_mask_d = merge_mask;
                pend_addr_d = hit_word;
            end
        end else if (state_q == S_FLUSH && pend_mask_q != '0) begin
            mem_we      = 1'b1;
            pend_mask_d = '0;
        end
    end

    always_ff @(posedge clk_bus or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            pend_word_q <= '0;
            pend_addr_q <= '0;
            pend_mask_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            pend_word_q <= pend_word_d;
            pend_addr_q <= pend_addr_d;
            pend_mask_q <= pend_mask_d;
            cnt_q       <= cnt_d;
        end
    end

    // Array is never reset; contents survive until the next load.
    always_ff @(posedge clk_bus) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

`ifdef GS_ROM_LOADABLE_CSUM_EN
    logic [15:0] csum_q, csum_d;

    always_comb begin
        csum_d = entry ? 16'd0 : csum_q;
        if (hit) csum_d = csum_d + {8'd0, loader_d};
    end

    always_ff @(posedge clk_bus or negedge reset_n) begin
        if (!reset_n) csum_q <= '0;
        else          csum_q <= csum_d;
    end

    assign csum = csum_q;
`endif

    logic [DATA_W-1:0] rd1_data_q, rd1_data_d;
    logic              rd1_valid_q, rd1_valid_d;

    always_comb begin
        rd1_valid_d = rd_req;
        rd1_data_d  = rd1_data_q;
        if (rd_req) rd1_data_d = ready ? mem_q[rd_addr] : '1;
    end

    always_ff @(posedge clk_bus or negedge reset_n) begin
        if (!reset_n) begin
            rd1_data_q  <= '0;
            rd1_valid_q <= 1'b0;
        end else begin
            rd1_data_q  <= rd1_data_d;
            rd1_valid_q <= rd1_valid_d;
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] rd2_data_q, rd2_data_d;
            logic              rd2_valid_q, rd2_valid_d;

            always_comb begin
                rd2_valid_d = rd1_valid_q;
                rd2_data_d  = rd1_valid_q ? rd1_data_q : rd2_data_q;
            end

            always_ff @(posedge clk_bus or negedge reset_n) begin
                if (!reset_n) begin
                    rd2_data_q  <= '0;
                    rd2_valid_q <= 1'b0;
                end else begin
                    rd2_data_q  <= rd2_data_d;
                    rd2_valid_q <= rd2_valid_d;
                end
            end

            assign rd_data  = rd2_data_q;
            assign rd_valid = rd2_valid_q;
        end else begin : g_lat1
            assign rd_data  = rd1_data_q;
            assign rd_valid = rd1_valid_q;
        end
    endgenerate

endmodule
